// File: rtl/spi_uart_pkg.sv
// Shared definitions for the SPI-to-UART frame scheduler: state encoding,
// line terminator bytes and the nibble-to-ASCII helper used by SPI_UART_HEX_EN builds.
package spi_uart_pkg;

  typedef enum logic [3:0] {
    IDLE         = 4'd0,
    SPI_REQ      = 4'd1,
    SPI_WAIT     = 4'd2,
    UART_REQ     = 4'd3,
    UART_WAIT    = 4'd4,
    UART_REQ_LO  = 4'd5,
    UART_WAIT_LO = 4'd6,
    EOL_CR       = 4'd7,
    EOL_CR_WAIT  = 4'd8,
    EOL_LF       = 4'd9,
    EOL_LF_WAIT  = 4'd10,
    DONE         = 4'd11
  } state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F'
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/spi_uart_tick.sv
// Free-running PERIOD counter for auto mode; held at zero while enable is low,
// tick is high in the last count of each period.
module spi_uart_tick #(
  parameter int unsigned PERIOD = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] tick_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_reg <= '0;
    end else if (!enable || tick_cnt_reg == LAST) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
    end
  end

  assign tick = enable && (tick_cnt_reg == LAST);

endmodule

// File: rtl/spi_uart_scheduler.sv
// Frame sequencer: reads NUM_REGS SPI registers and forwards each byte to the UART.
// Define SPI_UART_HEX_EN to send each byte as two ASCII hex chars and end frames with CR/LF.
module spi_uart_scheduler
  import spi_uart_pkg::*;
#(
  parameter logic [6:0]  ADDR_BASE = 7'h00,
  parameter int unsigned NUM_REGS  = 4,
  parameter int unsigned PERIOD    = 1_000_000,
  parameter int unsigned TIMEOUT   = 65535
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       start,
  output logic       spi_en,
  output logic       spi_rw,
  output logic [6:0] spi_addr,
  input  logic [7:0] spi_rdata,
  input  logic       spi_done,
  output logic       uart_en,
  output logic [7:0] uart_data,
  input  logic       uart_done,
  output logic       busy,
  output logic       err,
  output logic [7:0] frame_cnt
);

  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    LAST_IDX  = 4'(NUM_REGS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [3:0]    idx_reg, idx_next;
  logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [7:0]    frame_cnt_reg, frame_cnt_next;
  logic          err_reg, err_next;
  logic          busy_reg, busy_next;
  logic          spi_en_reg, spi_en_next;
  logic [6:0]    spi_addr_reg, spi_addr_next;
  logic          uart_en_reg, uart_en_next;
  logic [7:0]    uart_data_reg, uart_data_next;
  logic          tick;
  logic          wait_expired;
  logic          abort;
`ifdef SPI_UART_HEX_EN
  logic [3:0]    lo_nib_reg, lo_nib_next;
`endif

  spi_uart_tick #(.PERIOD(PERIOD)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      wait_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      spi_en_reg    <= 1'b0;
      spi_addr_reg  <= '0;
      uart_en_reg   <= 1'b0;
      uart_data_reg <= '0;
`ifdef SPI_UART_HEX_EN
      lo_nib_reg    <= '0;
`endif
    end else begin
      state_reg     <= state_next;
      idx_reg       <= idx_next;
      wait_cnt_reg  <= wait_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      err_reg       <= err_next;
      busy_reg      <= busy_next;
      spi_en_reg    <= spi_en_next;
      spi_addr_reg  <= spi_addr_next;
      uart_en_reg   <= uart_en_next;
      uart_data_reg <= uart_data_next;
`ifdef SPI_UART_HEX_EN
      lo_nib_reg    <= lo_nib_next;
`endif
    end
  end

  assign wait_expired = (wait_cnt_reg == WAIT_LAST);

  // Strobes are registered from the request state, so they appear one cycle after it.
  always_comb begin
    state_next     = state_reg;
    idx_next       = idx_reg;
    wait_cnt_next  = wait_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    err_next       = err_reg;
    busy_next      = busy_reg;
    spi_addr_next  = spi_addr_reg;
    uart_data_next = uart_data_reg;
    abort          = 1'b0;
    spi_en_next    = (state_reg == SPI_REQ);
`ifdef SPI_UART_HEX_EN
    lo_nib_next    = lo_nib_reg;
    uart_en_next   = (state_reg == UART_REQ) || (state_reg == UART_REQ_LO) ||
                     (state_reg == EOL_CR)   || (state_reg == EOL_LF);
`else
    uart_en_next   = (state_reg == UART_REQ);
`endif

    case (state_reg)
      IDLE: begin
        if (start || tick) begin
          busy_next  = 1'b1;
          idx_next   = '0;
          err_next   = 1'b0;
          state_next = SPI_REQ;
        end
      end
      SPI_REQ: begin
        spi_addr_next = ADDR_BASE + {3'b000, idx_reg};
        wait_cnt_next = '0;
        state_next    = SPI_WAIT;
      end
      SPI_WAIT: begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
        if (spi_done) begin
`ifdef SPI_UART_HEX_EN
          uart_data_next = hex_ascii(spi_rdata[7:4]);
          lo_nib_next    = spi_rdata[3:0];
`else
          uart_data_next = spi_rdata;
`endif
          state_next = UART_REQ;
        end else begin
          abort = wait_expired;
        end
      end
      UART_REQ: begin
        wait_cnt_next = '0;
        state_next    = UART_WAIT;
      end
      UART_WAIT: begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
        if (uart_done) begin
`ifdef SPI_UART_HEX_EN
          uart_data_next = hex_ascii(lo_nib_reg);
          state_next     = UART_REQ_LO;
`else
          idx_next   = idx_reg + 1'b1;
          state_next = (idx_reg == LAST_IDX) ? DONE : SPI_REQ;
`endif
        end else begin
          abort = wait_expired;
        end
      end
`ifdef SPI_UART_HEX_EN
      UART_REQ_LO: begin
        wait_cnt_next = '0;
        state_next    = UART_WAIT_LO;
      end
      UART_WAIT_LO: begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
        if (uart_done) begin
          idx_next = idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            uart_data_next = ASCII_CR;
            state_next     = EOL_CR;
          end else begin
            state_next = SPI_REQ;
          end
        end else begin
          abort = wait_expired;
        end
      end
      EOL_CR: begin
        wait_cnt_next = '0;
        state_next    = EOL_CR_WAIT;
      end
      EOL_CR_WAIT: begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
        if (uart_done) begin
          uart_data_next = ASCII_LF;
          state_next     = EOL_LF;
        end else begin
          abort = wait_expired;
        end
      end
      EOL_LF: begin
        wait_cnt_next = '0;
        state_next    = EOL_LF_WAIT;
      end
      EOL_LF_WAIT: begin
        wait_cnt_next = wait_cnt_reg + 1'b1;
        if (uart_done) begin
          state_next = DONE;
        end else begin
          abort = wait_expired;
        end
      end
`endif
      DONE: begin
        frame_cnt_next = frame_cnt_reg + 1'b1;
        busy_next      = 1'b0;
        state_next     = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A stalled handshake drops the frame without counting it.
    if (abort) begin
      err_next   = 1'b1;
      busy_next  = 1'b0;
      state_next = IDLE;
    end
  end

  assign spi_en    = spi_en_reg;
  assign spi_rw    = 1'b1;
  assign spi_addr  = spi_addr_reg;
  assign uart_en   = uart_en_reg;
  assign uart_data = uart_data_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;
  assign frame_cnt = frame_cnt_reg;

endmodule

// File: tb/tb_spi_uart_scheduler.sv
// Randomized bench for spi_uart_scheduler with SPI/UART responder models and a
// frame-level scoreboard; follows SPI_UART_HEX_EN when the build defines it.
`timescale 1ns/1ps
module tb_spi_uart_scheduler;

  localparam logic [6:0] ADDR_BASE = 7'h10;
  localparam int NUM_REGS = 4;
  localparam int PERIOD   = 200;
  localparam int TIMEOUT  = 50;

  logic       clk = 1'b0;
  logic       rst, enable, start;
  logic       spi_en, spi_rw, spi_done, uart_en, uart_done, busy, err;
  logic [6:0] spi_addr;
  logic [7:0] spi_rdata, uart_data, frame_cnt;
  logic       spi_done_rsp, spi_done_spur, uart_done_rsp, uart_done_spur;

  assign spi_done  = spi_done_rsp | spi_done_spur;
  assign uart_done = uart_done_rsp | uart_done_spur;

  spi_uart_scheduler #(
    .ADDR_BASE (ADDR_BASE),
    .NUM_REGS  (NUM_REGS),
    .PERIOD    (PERIOD),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .start     (start),
    .spi_en    (spi_en),
    .spi_rw    (spi_rw),
    .spi_addr  (spi_addr),
    .spi_rdata (spi_rdata),
    .spi_done  (spi_done),
    .uart_en   (uart_en),
    .uart_data (uart_data),
    .uart_done (uart_done),
    .busy      (busy),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int exp_frames = 0;

  int spi_lat_min = 5, spi_lat_max = 5, uart_lat_min = 20, uart_lat_max = 20;
  bit xor_data = 1'b1;
  bit spi_mute = 1'b0;

  logic [6:0] addr_q[$];
  logic [7:0] data_q[$];
  logic [7:0] uart_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] outs_now();
    return {5'b0, spi_en, uart_en, busy, err, frame_cnt, uart_data, spi_addr};
  endfunction

  function automatic logic [7:0] hexc(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + 8'(n);
    return 8'h41 + 8'(n) - 8'd10;
  endfunction

  // SPI slave model: answers each request after a random latency unless muted.
  initial begin
    spi_done_rsp = 1'b0;
    spi_rdata    = 8'h00;
    forever begin
      step();
      if (spi_en && !rst) begin
        int lat;
        bit aborted;
        logic [7:0] d;
        check_val("spi_rw", spi_rw, 1);
        addr_q.push_back(spi_addr);
        lat = $urandom_range(spi_lat_max, spi_lat_min);
        d = xor_data ? ({1'b0, spi_addr} ^ 8'hFF) : 8'($urandom);
        aborted = 1'b0;
        if (!spi_mute) begin
          for (int i = 0; i < lat; i++) begin
            step();
            if (rst) aborted = 1'b1;
          end
          if (!aborted) begin
            data_q.push_back(d);
            spi_rdata    = d;
            spi_done_rsp = 1'b1;
            step();
            spi_done_rsp = 1'b0;
            spi_rdata    = 8'($urandom);
          end
        end
      end
    end
  end

  // UART model: logs each byte and confirms it is still held when acknowledging.
  initial begin
    uart_done_rsp = 1'b0;
    forever begin
      step();
      if (uart_en && !rst) begin
        int lat;
        bit aborted;
        logic [7:0] held;
        held = uart_data;
        uart_q.push_back(held);
        lat = $urandom_range(uart_lat_max, uart_lat_min);
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          step();
          if (rst) aborted = 1'b1;
        end
        if (!aborted) begin
          check_val("uart_hold", uart_data, held);
          uart_done_rsp = 1'b1;
          step();
          uart_done_rsp = 1'b0;
        end
      end
    end
  end

  task automatic clear_logs();
    addr_q.delete();
    data_q.delete();
    uart_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_busy(input logic val, input int limit, input string tag);
    int n = 0;
    while (busy !== val && n < limit) begin
      step();
      n++;
    end
    if (busy !== val) check_val({tag, "_busy_wait"}, busy, val);
  endtask

  // Expected UART stream derived from the bytes the SPI model actually returned.
  task automatic verify_frame(input string tag);
    logic [7:0] exp_q[$];
    foreach (data_q[i]) begin
`ifdef SPI_UART_HEX_EN
      exp_q.push_back(hexc(data_q[i][7:4]));
      exp_q.push_back(hexc(data_q[i][3:0]));
`else
      exp_q.push_back(data_q[i]);
`endif
    end
`ifdef SPI_UART_HEX_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
    check_val({tag, "_spi_reqs"}, addr_q.size(), NUM_REGS);
    for (int i = 0; i < NUM_REGS && i < addr_q.size(); i++)
      check_val($sformatf("%s_addr%0d", tag, i), addr_q[i], 7'(ADDR_BASE + i));
    check_val({tag, "_uart_bytes"}, uart_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < uart_q.size(); i++)
      check_val($sformatf("%s_uart%0d", tag, i), uart_q[i], exp_q[i]);
    check_val({tag, "_frame_cnt"}, frame_cnt, 8'(exp_frames));
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_err"}, err, 0);
    $display("frame %s: spi_reqs=%0d uart_bytes=%0d frame_cnt=%0d", tag, addr_q.size(), uart_q.size(), frame_cnt);
    clear_logs();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int c0;
    logic seen;
    rst = 1'b1; enable = 1'b0; start = 1'b0;
    spi_done_spur = 1'b0; uart_done_spur = 1'b0;
    repeat (3) step();
    check_val("reset_outputs", outs_now(), 0);
    rst = 1'b0;
    step();

    // Fixed-latency frame with data = addr ^ 0xFF, plus start-to-request latency.
    pulse_start();
    n = 1;
    while (!spi_en && n < 10) begin
      step();
      n++;
    end
    check_val("start_latency", n, 2);
    wait_busy(1'b0, 2000, "t1");
    exp_frames++;
    verify_frame("t1");

    // Randomized latencies and data.
    xor_data = 1'b0;
    spi_lat_min = 1; spi_lat_max = 8; uart_lat_min = 1; uart_lat_max = 25;
    for (int k = 0; k < 4; k++) begin
      pulse_start();
      wait_busy(1'b0, 3000, "rnd");
      exp_frames++;
      verify_frame($sformatf("rnd%0d", k));
    end

    // Start while busy is ignored and not queued.
    pulse_start();
    repeat (10) step();
    pulse_start();
    wait_busy(1'b0, 3000, "busy_start");
    exp_frames++;
    verify_frame("busy_start");
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen |= busy | spi_en;
    end
    check_val("no_queued_start", seen, 0);

    // Spurious spi_done in IDLE.
    spi_done_spur = 1'b1;
    step();
    spi_done_spur = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= spi_en | uart_en | busy;
    end
    check_val("spur_spi_idle", seen, 0);
    check_val("spur_spi_frame_cnt", frame_cnt, 8'(exp_frames));

    // Spurious uart_done while waiting on SPI.
    spi_lat_min = 10; spi_lat_max = 10;
    pulse_start();
    n = 0;
    while (!spi_en && n < 10) begin
      step();
      n++;
    end
    repeat (2) step();
    uart_done_spur = 1'b1;
    step();
    uart_done_spur = 1'b0;
    check_val("spur_uart_no_strobe", uart_en, 0);
    wait_busy(1'b0, 3000, "spur_uart");
    exp_frames++;
    verify_frame("spur_uart");

    // SPI timeout: err after TIMEOUT cycles in SPI_WAIT, frame not counted.
    spi_lat_min = 1; spi_lat_max = 8;
    spi_mute = 1'b1;
    pulse_start();
    n = 0;
    while (!spi_en && n < 10) begin
      step();
      n++;
    end
    n = 0;
    while (!err && n < 200) begin
      step();
      n++;
    end
    check_val("timeout_cycles", n, TIMEOUT);
    check_val("timeout_busy", busy, 0);
    check_val("timeout_frame_cnt", frame_cnt, 8'(exp_frames));
    $display("timeout: err after %0d cycles", n);
    spi_mute = 1'b0;
    repeat (5) step();
    clear_logs();
    pulse_start();
    check_val("err_cleared_on_start", err, 0);
    wait_busy(1'b0, 3000, "after_timeout");
    exp_frames++;
    verify_frame("after_timeout");

    // Reset while in UART_WAIT.
    xor_data = 1'b1;
    pulse_start();
    n = 0;
    while (!uart_en && n < 200) begin
      step();
      n++;
    end
    repeat (2) step();
    #1 rst = 1'b1;
    #1 check_val("rst_midframe_outputs", outs_now(), 0);
    step();
    step();
    rst = 1'b0;
    repeat (40) step();
    clear_logs();
    exp_frames = 0;
    check_val("post_rst_outputs", outs_now(), 0);
    pulse_start();
    wait_busy(1'b0, 3000, "post_rst");
    exp_frames++;
    verify_frame("post_rst");

    // Auto mode: frames at every PERIOD tick, start coinciding with tick gives one frame.
    xor_data = 1'b0;
    spi_lat_min = 1; spi_lat_max = 5; uart_lat_min = 1; uart_lat_max = 8;
    enable = 1'b1;
    c0 = cyc;
    for (int f = 0; f < 3; f++) begin
      if (f == 2) begin
        while (cyc < c0 + 3 * PERIOD - 1) step();
        pulse_start();
      end
      n = 0;
      while (!busy && n < 400) begin
        step();
        n++;
      end
      check_val($sformatf("auto_start%0d", f), cyc - c0, PERIOD * (f + 1));
      if (f == 1) begin
        repeat (5) step();
        pulse_start();
      end
      wait_busy(1'b0, 3000, "auto");
      if (f == 2) enable = 1'b0;
      exp_frames++;
      verify_frame($sformatf("auto%0d", f));
    end
    repeat (250) step();
    check_val("auto_off_frame_cnt", frame_cnt, 8'(exp_frames));
    check_val("auto_off_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
